// File: rtl/fixed_scale_multiplier.sv
// Registered multiply of two scaled fixed-point words (13-bit mantissa, 3-bit fraction count),
// renormalised into the same format with arithmetic truncation and saturation.
module fixed_scale_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] first_operand,
  input  logic [15:0] second_operand,
  output logic [15:0] out
);

  logic signed [12:0] w_mant_a;
  logic signed [12:0] w_mant_b;
  logic        [2:0]  w_scale_a;
  logic        [2:0]  w_scale_b;
  logic signed [25:0] w_prod;
  logic        [3:0]  w_sum;
  logic        [3:0]  w_kmin;
  logic signed [25:0] w_sh   [16];
  logic        [15:0] w_fits;
  logic        [3:0]  w_k;
  logic               w_found;
  logic signed [12:0] w_mant_res;
  logic        [2:0]  w_scale_res;
  logic        [15:0] r_out;

  assign w_mant_a  = first_operand[15:3];
  assign w_mant_b  = second_operand[15:3];
  assign w_scale_a = first_operand[2:0];
  assign w_scale_b = second_operand[2:0];

  assign w_prod = 26'(w_mant_a) * 26'(w_mant_b);
  assign w_sum  = {1'b0, w_scale_a} + {1'b0, w_scale_b};
  assign w_kmin = (w_sum > 4'd7) ? (w_sum - 4'd7) : 4'd0;

  // Every candidate shift is evaluated in parallel; the selector below picks the smallest legal one.
  for (genvar g = 0; g < 16; g++) begin : g_shift
    assign w_sh[g]   = w_prod >>> g;
    assign w_fits[g] = (w_sh[g] >= -26'sd4096) && (w_sh[g] <= 26'sd4095);
  end

  always_comb begin
    w_found = 1'b0;
    w_k     = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if ((4'(k) >= w_kmin) && (4'(k) <= w_sum) && w_fits[k]) begin
        w_found = 1'b1;
        w_k     = 4'(k);
      end
    end
  end

  // A zero product always fits at k = kmin, which yields scale min(S, 7) without a special case.
  always_comb begin
    w_mant_res  = 13'sd0;
    w_scale_res = 3'd0;
    if (w_found) begin
      w_mant_res  = w_sh[w_k][12:0];
      w_scale_res = 3'(w_sum - w_k);
    end else begin
      w_mant_res  = w_prod[25] ? -13'sd4096 : 13'sd4095;
      w_scale_res = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= 16'h0000;
    end else begin
      r_out <= {w_mant_res, w_scale_res};
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_fixed_scale_multiplier.sv
// Directed-vector bench for fixed_scale_multiplier with hand-computed expected words.
module tb_fixed_scale_multiplier;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] out_w;
  int          total;
  int          bad;

  fixed_scale_multiplier dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .first_operand (a),
    .second_operand(b),
    .out           (out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input string tag, input logic [15:0] va, input logic [15:0] vb,
                       input logic [15:0] exp);
    @(negedge clk);
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    chk(tag, out_w, exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a     = 16'h0039;
    b     = 16'h02A4;
    #1;
    chk("reset_async", out_w, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_hold", out_w, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    apply("basic",        16'h0039, 16'h02A4, 16'h1265);
    apply("neg_a",        16'hFF99, 16'h0020, 16'hFE61);
    apply("neg_b",        16'h00DA, 16'hFFE0, 16'hFCA2);
    apply("scale_trunc",  16'h051D, 16'h058D, 16'h70B7);
    apply("scale_neg",    16'h1E07, 16'hFC07, 16'hE207);
    apply("mant_ovf",     16'h3FFB, 16'h0020, 16'h7FF2);
    apply("sat_pos",      16'h7FF8, 16'h7FF8, 16'h7FF8);
    apply("sat_neg",      16'h8000, 16'h7FF8, 16'h8000);
    apply("zero_s5",      16'h0003, 16'h0102, 16'h0005);
    apply("zero_s12",     16'h0007, 16'h0005, 16'h0007);
    apply("floor_neg",    16'hFFFF, 16'h0027, 16'hFFFF);
    apply("floor_pos",    16'h0027, 16'h000F, 16'h0007);
    apply("sat_limited",  16'h7FF9, 16'h7FF8, 16'h7FF8);
    apply("sat_negneg",   16'h8000, 16'h8000, 16'h7FF8);
    apply("edge_min",     16'h8001, 16'h0008, 16'h8001);
    apply("edge_4096",    16'h4000, 16'h0010, 16'h7FF8);
    apply("edge_shift1",  16'h4001, 16'h0010, 16'h4000);

    // Mid-cycle reset pulse clears the output immediately and drops the in-flight product.
    @(negedge clk);
    a = 16'h00DA;
    b = 16'hFFE0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid", out_w, 16'h0000);
    @(posedge clk);
    #1;
    chk("reset_mid_hold", out_w, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset", out_w, 16'hFCA2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
